mix_scheduler: RTL and testbench

//   Sample-rate controller for the voice mixing datapath. Runs a free-running sample-period counter and

---
 rtl/mix_scheduler_pkg.sv | 26 ++
 rtl/mix_scheduler_if.sv | 30 +++
 rtl/mix_scheduler_divider.sv | 58 +++++
 rtl/mix_scheduler.sv | 127 ++++++++++++
 tb/tb_mix_scheduler.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/mix_scheduler_pkg.sv
// Shared types and width helpers for the voice-mix scheduler.
// Optional build macro MIX_ROUND_EN (round-to-nearest output) is consumed by mix_scheduler.
package mix_scheduler_pkg;

  localparam int NUM_VOICES_D = 13;
  localparam int SAMPLE_W_D   = 12;
  localparam int OUT_W_D      = 8;

  function automatic int sum_width(input int sample_w, input int num_voices);
    return sample_w + $clog2(num_voices);
  endfunction

  localparam int SUM_W = sum_width(SAMPLE_W_D, NUM_VOICES_D);

  typedef logic [SAMPLE_W_D-1:0] sample_t;
  typedef logic [SUM_W-1:0]      sum_t;
  typedef logic [OUT_W_D-1:0]    out_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DIVIDE  = 2'd2,
    DONE    = 2'd3
  } mix_state_t;

endpackage

// File: rtl/mix_scheduler_if.sv
// Bus between the mix scheduler and its environment: voice inputs in, mixed sample out.
// Handshake: out_valid is a 1-cycle strobe with no ready; mixed_sample/active_count hold until the next strobe.
interface mix_scheduler_if
  import mix_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_D,
  parameter int SAMPLE_W   = SAMPLE_W_D,
  parameter int OUT_W      = OUT_W_D
) ();

  logic                en;
  logic [SAMPLE_W-1:0] voice [NUM_VOICES];
  logic                sample_tick;
  logic                busy;
  logic [3:0]          active_count;
  logic [OUT_W-1:0]    mixed_sample;
  logic                out_valid;
  logic [1:0]          state;

  modport master (
    output en, voice,
    input  sample_tick, busy, active_count, mixed_sample, out_valid, state
  );

  modport slave (
    input  en, voice,
    output sample_tick, busy, active_count, mixed_sample, out_valid, state
  );

endinterface

// File: rtl/mix_scheduler_divider.sv
// Restoring divider: one quotient bit per cycle, MSB first, N_W iterations after load.
// done is high during the final iteration, so quotient is valid from the following cycle.
module mix_scheduler_divider #(
  parameter int N_W = 16,
  parameter int D_W = 4,
  parameter int Q_W = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic [Q_W-1:0] quotient,
  output logic           done
);

  localparam int IT_W = $clog2(N_W + 1);

  logic [N_W-1:0]  q;
  logic [D_W-1:0]  d;
  logic [D_W-1:0]  rem;
  logic [IT_W-1:0] iter;
  logic [D_W:0]    shifted;
  logic [D_W:0]    rem_next;
  logic            fits;
  logic            unused_rem_msb;

  always_comb begin
    shifted  = {rem, q[N_W-1]};
    fits     = (shifted >= {1'b0, d});
    rem_next = fits ? (shifted - {1'b0, d}) : shifted;
  end

  // The partial remainder is always below the divisor, so its top bit is always zero.
  assign unused_rem_msb = rem_next[D_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      d    <= '0;
      rem  <= '0;
      iter <= '0;
    end else if (load) begin
      q    <= dividend;
      d    <= divisor;
      rem  <= '0;
      iter <= IT_W'(N_W);
    end else if (iter != '0) begin
      q    <= {q[N_W-2:0], fits};
      rem  <= rem_next[D_W-1:0];
      iter <= iter - IT_W'(1);
    end
  end

  assign done     = (iter == IT_W'(1));
  assign quotient = (d == '0) ? '0 : q[Q_W-1:0];

endmodule

// File: rtl/mix_scheduler.sv
// Sample-rate controller: ticks every CLK_PER_SAMPLE cycles, snapshots voices, publishes their average.
// Build macro MIX_ROUND_EN selects round-to-nearest output; default truncates.
module mix_scheduler
  import mix_scheduler_pkg::*;
#(
  parameter int NUM_VOICES     = NUM_VOICES_D,
  parameter int SAMPLE_W       = SAMPLE_W_D,
  parameter int OUT_W          = OUT_W_D,
  parameter int CLK_PER_SAMPLE = 1000
) (
  input logic            clk,
  input logic            rst,
  mix_scheduler_if.slave bus
);

  localparam int SW    = sum_width(SAMPLE_W, NUM_VOICES);
  localparam int CNT_W = $clog2(CLK_PER_SAMPLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_SAMPLE - 1);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_CAPTURE = CAPTURE;
  localparam logic [1:0] ST_DIVIDE  = DIVIDE;
  localparam logic [1:0] ST_DONE    = DONE;

  // A period shorter than one full calculation would let a tick land while busy.
  if (CLK_PER_SAMPLE < SW + 4) begin : g_period_check
    $error("mix_scheduler: CLK_PER_SAMPLE must be at least SUM_W+4");
  end

  logic [CNT_W-1:0]    cnt;
  logic                tick;
  logic [1:0]          state;
  logic [SAMPLE_W-1:0] snap [NUM_VOICES];
  logic [SW-1:0]       sum;
  logic [3:0]          n;
  logic                div_done;
  logic [SAMPLE_W-1:0] quot;
  logic [OUT_W-1:0]    result;
  logic                unused_quot_lsbs;
  logic [OUT_W-1:0]    mixed_r;
  logic [3:0]          count_r;
  logic                valid_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (bus.en) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick = bus.en && !rst && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++) snap[i] <= '0;
    end else if (state == ST_IDLE && tick) begin
      for (int i = 0; i < NUM_VOICES; i++) snap[i] <= bus.voice[i];
    end
  end

  // Snapshot stays frozen until the next tick, so sum and n are stable through DONE.
  always_comb begin
    sum = '0;
    n   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      sum = sum + SW'(snap[i]);
      if (snap[i] != '0) n = n + 4'd1;
    end
  end

  mix_scheduler_divider #(
    .N_W (SW),
    .D_W (4),
    .Q_W (SAMPLE_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_CAPTURE),
    .dividend (sum),
    .divisor  (n),
    .quotient (quot),
    .done     (div_done)
  );

  assign unused_quot_lsbs = ^quot[SAMPLE_W-OUT_W-1:0];

`ifdef MIX_ROUND_EN
  logic [OUT_W:0] rounded;
  assign rounded = {1'b0, quot[SAMPLE_W-1 -: OUT_W]}
                 + {{OUT_W{1'b0}}, quot[SAMPLE_W-OUT_W-1]};
  assign result  = rounded[OUT_W] ? '1 : rounded[OUT_W-1:0];
`else
  assign result = quot[SAMPLE_W-1 -: OUT_W];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      mixed_r <= '0;
      count_r <= '0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        ST_IDLE:    if (tick) state <= ST_CAPTURE;
        ST_CAPTURE: state <= ST_DIVIDE;
        ST_DIVIDE:  if (div_done) state <= ST_DONE;
        ST_DONE: begin
          mixed_r <= result;
          count_r <= n;
          valid_r <= 1'b1;
          state   <= ST_IDLE;
        end
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign bus.sample_tick  = tick;
  assign bus.busy         = (state != ST_IDLE);
  assign bus.active_count = count_r;
  assign bus.mixed_sample = mixed_r;
  assign bus.out_valid    = valid_r;
  assign bus.state        = state;

endmodule

// File: tb/tb_mix_scheduler.sv
// Directed bench for mix_scheduler: vector table plus reset-abort and snapshot sequences.
module tb_mix_scheduler;
  import mix_scheduler_pkg::*;

  localparam int CPS     = 40;
  localparam int LAT     = SUM_W + 3;
  localparam int BUDGET  = 2 * CPS + LAT + 10;
  localparam int NVEC    = 9;
`ifdef MIX_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  typedef struct {
    logic [NUM_VOICES_D-1:0][SAMPLE_W_D-1:0] v;
    int exp_trunc;
    int exp_round;
    int exp_n;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mix_scheduler_if bus ();

  mix_scheduler #(.CLK_PER_SAMPLE(CPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp       = 0;
  int n_fail      = 0;
  int cyc         = 0;
  int prev_tick   = -1;
  int last_tick   = -1;
  int tick_total  = 0;
  int valid_total = 0;
  bit got_valid   = 1'b0;
  bit got_tick    = 1'b0;
  logic [11:0] exp_q[$];
  vec_t vecs [NVEC];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock; observe outputs 1 time unit after the rising edge.
  task automatic step();
    logic [11:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (rst || !bus.en) prev_tick = -1;
    if (bus.sample_tick) begin
      tick_total++;
      got_tick = 1'b1;
      if (prev_tick >= 0) check("tick_period", cyc - prev_tick, CPS);
      prev_tick = cyc;
      last_tick = cyc;
    end
    if (bus.out_valid) begin
      valid_total++;
      got_valid = 1'b1;
      check("latency", cyc - last_tick, LAT);
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("mixed_sample", int'(bus.mixed_sample), int'(e[7:0]));
        check("active_count", int'(bus.active_count), int'(e[11:8]));
      end
    end
  endtask

  task automatic set_voices(input logic [NUM_VOICES_D-1:0][SAMPLE_W_D-1:0] v);
    for (int i = 0; i < NUM_VOICES_D; i++) bus.voice[i] = v[i];
  endtask

  task automatic wait_valid(input string name);
    int i;
    logic [7:0] held;
    got_valid = 1'b0;
    i = 0;
    while (i < BUDGET && !got_valid) begin
      step();
      i++;
    end
    check({name, "_timeout"}, int'(got_valid), 1);
    held = bus.mixed_sample;
    step();
    check({name, "_pulse_width"}, int'(bus.out_valid), 0);
    check({name, "_held"}, int'(bus.mixed_sample), int'(held));
  endtask

  task automatic wait_tick(input string name);
    int i;
    got_tick = 1'b0;
    i = 0;
    while (i < BUDGET && !got_tick) begin
      step();
      i++;
    end
    check({name, "_timeout"}, int'(got_tick), 1);
  endtask

  function automatic void init_vecs();
    for (int k = 0; k < NVEC; k++) vecs[k].v = '0;
    vecs[0].v[0] = 12'd4095; vecs[0].v[1] = 12'd4095; vecs[0].v[2] = 12'd4095;
    vecs[0].exp_trunc = 255; vecs[0].exp_round = 255; vecs[0].exp_n = 3;
    for (int i = 0; i < NUM_VOICES_D; i++) vecs[1].v[i] = 12'd4095;
    vecs[1].exp_trunc = 255; vecs[1].exp_round = 255; vecs[1].exp_n = 13;
    vecs[2].exp_trunc = 0;   vecs[2].exp_round = 0;   vecs[2].exp_n = 0;
    vecs[3].v[0] = 12'd24;   vecs[3].v[1] = 12'd24;
    vecs[3].exp_trunc = 1;   vecs[3].exp_round = 2;   vecs[3].exp_n = 2;
    vecs[4].v[0] = 12'd4095; vecs[4].v[1] = 12'd4088;
    vecs[4].exp_trunc = 255; vecs[4].exp_round = 255; vecs[4].exp_n = 2;
    vecs[5].v[5] = 12'd1000;
    vecs[5].exp_trunc = 62;  vecs[5].exp_round = 63;  vecs[5].exp_n = 1;
    vecs[6].v[0] = 12'd100;  vecs[6].v[1] = 12'd200;  vecs[6].v[2] = 12'd300;
    vecs[6].exp_trunc = 12;  vecs[6].exp_round = 13;  vecs[6].exp_n = 3;
    vecs[7].v[12] = 12'd4095; vecs[7].v[0] = 12'd1;
    vecs[7].exp_trunc = 128; vecs[7].exp_round = 128; vecs[7].exp_n = 2;
    vecs[8].v[0] = 12'd16;   vecs[8].v[1] = 12'd17;
    vecs[8].exp_trunc = 1;   vecs[8].exp_round = 1;   vecs[8].exp_n = 2;
  endfunction

  function automatic logic [11:0] pack_exp(input int n, input int m);
    return {4'(n), 8'(m)};
  endfunction

  initial begin
    logic [NUM_VOICES_D-1:0][SAMPLE_W_D-1:0] v;
    init_vecs();
    bus.en = 1'b0;
    v = '0;
    set_voices(v);

    // Reset held for three cycles.
    rst = 1'b1;
    repeat (3) step();
    check("rst_sample_tick", int'(bus.sample_tick), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_active_count", int'(bus.active_count), 0);
    check("rst_mixed_sample", int'(bus.mixed_sample), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);

    // Counter disabled: no ticks and no results.
    rst = 1'b0;
    repeat (2 * CPS) step();
    check("en0_ticks", tick_total, 0);
    check("en0_valids", valid_total, 0);

    // Vector table, one sample period each.
    bus.en = 1'b1;
    for (int k = 0; k < NVEC; k++) begin
      set_voices(vecs[k].v);
      exp_q.push_back(pack_exp(vecs[k].exp_n, ROUND ? vecs[k].exp_round : vecs[k].exp_trunc));
      wait_valid($sformatf("vec%0d", k));
    end

    // Reset during DIVIDE aborts the sample, then a clean restart.
    v = '0;
    v[0] = 12'd4095;
    set_voices(v);
    wait_tick("abort_tick");
    repeat (5) step();
    check("abort_in_divide", int'(bus.state), 2);
    rst = 1'b1;
    step();
    check("abort_busy", int'(bus.busy), 0);
    check("abort_mixed", int'(bus.mixed_sample), 0);
    check("abort_count", int'(bus.active_count), 0);
    rst = 1'b0;
    valid_total = 0;
    repeat (30) step();
    check("abort_no_valid", valid_total, 0);
    exp_q.push_back(pack_exp(1, 255));
    wait_valid("restart");

    // Voices changed mid-calculation must not affect the snapshot result.
    v = '0;
    v[0] = 12'd800;
    v[1] = 12'd400;
    set_voices(v);
    exp_q.push_back(pack_exp(2, ROUND ? 38 : 37));
    wait_tick("snap_tick");
    repeat (4) step();
    for (int i = 0; i < NUM_VOICES_D; i++) v[i] = 12'd4095;
    set_voices(v);
    wait_valid("snapshot");

    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
